// File: rtl/nclic_dispatch_pkg.sv
// Shared types for the nclic dispatch sequencer: index/priority widths,
// the saved-context payload and the dispatch FSM encoding.
package nclic_dispatch_pkg;

    localparam int unsigned IdxWidth  = 5;
    localparam int unsigned PrioWidth = 4;

    typedef logic [IdxWidth-1:0]  int_idx_t;
    typedef logic [PrioWidth-1:0] int_prio_t;

    // One saved interrupt context on the priority stack.
    typedef struct packed {
        int_idx_t  idx;
        int_prio_t prio;
    } nclic_ctx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        ACTIVE = 2'd2
    } dispatch_state_t;

    // Strictly-greater priority test: equal priority never preempts.
    function automatic logic prio_beats(input int_prio_t cand, input int_prio_t ref_prio);
        return cand > ref_prio;
    endfunction

endpackage

// File: rtl/nclic_prio_stack.sv
// LIFO of saved interrupt contexts.
// Ports: clk, rst_n (async active-low), push/pop (never both in one cycle),
//        push_data, top (0 when empty), count, full, empty.
module nclic_prio_stack
    import nclic_dispatch_pkg::*;
#(
    parameter int unsigned StackDepth = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              push,
    input  logic                              pop,
    input  nclic_ctx_t                        push_data,
    output nclic_ctx_t                        top,
    output logic [$clog2(StackDepth+1)-1:0]   count,
    output logic                              full,
    output logic                              empty
);

    localparam int unsigned CntW  = $clog2(StackDepth + 1);
    localparam int unsigned AddrW = (StackDepth > 1) ? $clog2(StackDepth) : 1;

    nclic_ctx_t mem [StackDepth];

    assign full  = (count == CntW'(StackDepth));
    assign empty = (count == '0);
    assign top   = empty ? '0 : mem[AddrW'(count - CntW'(1))];

    // Storage needs no reset: entries above count are never read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[AddrW'(count)] <= push_data;
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CntW'(1);
        end else if (pop && !empty) begin
            count <= count - CntW'(1);
        end
    end

endmodule

// File: rtl/nclic_dispatch.sv
// Sequencer between the nclic arbiter and the core trap interface.
// Qualifies the arbiter winner against the running priority, offers the
// vector with a take/ack handshake, clears the pending bit on acceptance,
// and tracks nesting on a priority stack (mret, tail-chaining).
// Ports: clk, reset (async active-low); arbiter i_int/i_idx/i_prio,
//        i_global_ie, i_vectors (flattened table, entry n at n*VecWidth);
//        offer o_take/o_tail/o_vector/o_idx, core i_ack/i_mret;
//        pending clear o_clr_we/o_clr_idx; status o_cur_prio/o_cur_idx,
//        o_depth, o_overflow (sticky).
module nclic_dispatch
    import nclic_dispatch_pkg::*;
#(
    parameter int unsigned NoInterrupts = 16,
    parameter int unsigned StackDepth   = 8,
    parameter int unsigned VecWidth     = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_int,
    input  logic [IdxWidth-1:0]               i_idx,
    input  logic [PrioWidth-1:0]              i_prio,
    input  logic                              i_global_ie,
    input  logic [NoInterrupts*VecWidth-1:0]  i_vectors,
    output logic                              o_take,
    output logic                              o_tail,
    output logic [VecWidth-1:0]               o_vector,
    output logic [IdxWidth-1:0]               o_idx,
    input  logic                              i_ack,
    input  logic                              i_mret,
    output logic                              o_clr_we,
    output logic [IdxWidth-1:0]               o_clr_idx,
    output logic [PrioWidth-1:0]              o_cur_prio,
    output logic [IdxWidth-1:0]               o_cur_idx,
    output logic [$clog2(StackDepth+1)-1:0]   o_depth,
    output logic                              o_overflow
);

    localparam int unsigned CntW = $clog2(StackDepth + 1);

    dispatch_state_t       state_q, state_d;
    logic                  take_q, take_d;
    logic                  tail_q, tail_d;
    int_idx_t              off_idx_q, off_idx_d;
    int_prio_t             off_prio_q, off_prio_d;
    logic [VecWidth-1:0]   off_vec_q, off_vec_d;
    nclic_ctx_t            cur_q, cur_d;
    logic                  clr_we_q, clr_we_d;
    int_idx_t              clr_idx_q, clr_idx_d;
    logic                  ovf_q, ovf_d;
    logic                  latch_offer;

    logic                  push, pop;
    nclic_ctx_t            push_data, top;
    logic [CntW-1:0]       count;
    logic                  full, empty;

    logic [VecWidth-1:0]   win_vec;
    logic                  idx_ok, arb_ok, qual, tail_ok;

    nclic_prio_stack #(
        .StackDepth (StackDepth)
    ) u_stack (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .top       (top),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Vector lookup for the current winner; out-of-range indices read 0.
    always_comb begin
        win_vec = '0;
        for (int unsigned i = 0; i < NoInterrupts; i++) begin
            if (32'(i_idx) == i) begin
                win_vec = i_vectors[i*VecWidth +: VecWidth];
            end
        end
    end

    assign idx_ok  = 32'(i_idx) < NoInterrupts;
    assign arb_ok  = i_int & i_global_ie & idx_ok;
    assign qual    = arb_ok & prio_beats(i_prio, cur_q.prio);
    // Tail-chain compares against the level we would return to.
    assign tail_ok = arb_ok & prio_beats(i_prio, top.prio);

    // Next-state and register-input logic.
    always_comb begin
        state_d     = state_q;
        take_d      = take_q;
        tail_d      = tail_q;
        off_idx_d   = off_idx_q;
        off_prio_d  = off_prio_q;
        off_vec_d   = off_vec_q;
        cur_d       = cur_q;
        clr_we_d    = 1'b0;
        clr_idx_d   = clr_idx_q;
        ovf_d       = ovf_q;
        push        = 1'b0;
        pop         = 1'b0;
        push_data   = cur_q;
        latch_offer = 1'b0;

        case (state_q)
            IDLE: begin
                if (qual) begin
                    state_d     = PEND;
                    take_d      = 1'b1;
                    tail_d      = 1'b0;
                    latch_offer = 1'b1;
                end
            end

            ACTIVE: begin
                if (i_mret) begin
                    if (tail_ok) begin
                        state_d     = PEND;
                        take_d      = 1'b1;
                        tail_d      = 1'b1;
                        latch_offer = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        cur_d   = top;
                        state_d = (count == CntW'(1)) ? IDLE : ACTIVE;
                    end
                end else if (qual) begin
                    if (!full) begin
                        state_d     = PEND;
                        take_d      = 1'b1;
                        tail_d      = 1'b0;
                        latch_offer = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end

            PEND: begin
                if (i_ack) begin
                    // A tail offer reuses the slot of the handler it replaces.
                    state_d   = ACTIVE;
                    take_d    = 1'b0;
                    tail_d    = 1'b0;
                    push      = !tail_q;
                    cur_d     = '{idx: off_idx_q, prio: off_prio_q};
                    clr_we_d  = 1'b1;
                    clr_idx_d = off_idx_q;
                end else if (i_mret) begin
                    // Withdraw. Tail offer: finish the deferred pop. Normal
                    // offer: cur is still the running handler, so pop it.
                    // Both reduce to popping into cur when anything is stacked.
                    take_d = 1'b0;
                    tail_d = 1'b0;
                    if (!empty) begin
                        pop     = 1'b1;
                        cur_d   = top;
                        state_d = (count == CntW'(1)) ? IDLE : ACTIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                take_d  = 1'b0;
                tail_d  = 1'b0;
            end
        endcase

        if (latch_offer) begin
            off_idx_d  = i_idx;
            off_prio_d = i_prio;
            off_vec_d  = win_vec;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            take_q     <= 1'b0;
            tail_q     <= 1'b0;
            off_idx_q  <= '0;
            off_prio_q <= '0;
            off_vec_q  <= '0;
            cur_q      <= '0;
            clr_we_q   <= 1'b0;
            clr_idx_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            take_q     <= take_d;
            tail_q     <= tail_d;
            off_idx_q  <= off_idx_d;
            off_prio_q <= off_prio_d;
            off_vec_q  <= off_vec_d;
            cur_q      <= cur_d;
            clr_we_q   <= clr_we_d;
            clr_idx_q  <= clr_idx_d;
            ovf_q      <= ovf_d;
        end
    end

    assign o_take     = take_q;
    assign o_tail     = tail_q;
    assign o_vector   = off_vec_q;
    assign o_idx      = off_idx_q;
    assign o_clr_we   = clr_we_q;
    assign o_clr_idx  = clr_idx_q;
    assign o_cur_prio = cur_q.prio;
    assign o_cur_idx  = cur_q.idx;
    assign o_depth    = count;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_nclic_dispatch.sv
// Directed bench for nclic_dispatch with offer/clear scoreboards.
module tb_nclic_dispatch;
    import nclic_dispatch_pkg::*;

    localparam int unsigned NInt  = 16;
    localparam int unsigned Depth = 2;
    localparam int unsigned VW    = 32;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  i_int;
    logic [IdxWidth-1:0]   i_idx;
    logic [PrioWidth-1:0]  i_prio;
    logic                  i_global_ie;
    logic [NInt*VW-1:0]    i_vectors;
    logic                  o_take, o_tail;
    logic [VW-1:0]         o_vector;
    logic [IdxWidth-1:0]   o_idx;
    logic                  i_ack, i_mret;
    logic                  o_clr_we;
    logic [IdxWidth-1:0]   o_clr_idx;
    logic [PrioWidth-1:0]  o_cur_prio;
    logic [IdxWidth-1:0]   o_cur_idx;
    logic [1:0]            o_depth;
    logic                  o_overflow;

    nclic_dispatch #(
        .NoInterrupts (NInt),
        .StackDepth   (Depth),
        .VecWidth     (VW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_int       (i_int),
        .i_idx       (i_idx),
        .i_prio      (i_prio),
        .i_global_ie (i_global_ie),
        .i_vectors   (i_vectors),
        .o_take      (o_take),
        .o_tail      (o_tail),
        .o_vector    (o_vector),
        .o_idx       (o_idx),
        .i_ack       (i_ack),
        .i_mret      (i_mret),
        .o_clr_we    (o_clr_we),
        .o_clr_idx   (o_clr_idx),
        .o_cur_prio  (o_cur_prio),
        .o_cur_idx   (o_cur_idx),
        .o_depth     (o_depth),
        .o_overflow  (o_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]          vec;
        logic [IdxWidth-1:0]  idx;
        logic                 tail;
    } offer_t;

    offer_t              offer_q[$];
    logic [IdxWidth-1:0] clr_q[$];
    int                  n_tests = 0;
    int                  n_fail  = 0;

    function automatic logic [31:0] vec_of(input int i);
        return (i == 3) ? 32'h100 : 32'h2000 + 32'(i) * 32'h40;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_arb(input logic v, input int idx, input int prio);
        i_int  = v;
        i_idx  = IdxWidth'(idx);
        i_prio = PrioWidth'(prio);
    endtask

    task automatic expect_offer(input int idx, input logic tail);
        offer_t e;
        e.vec  = vec_of(idx);
        e.idx  = IdxWidth'(idx);
        e.tail = tail;
        offer_q.push_back(e);
    endtask

    task automatic check_offer(input string tag);
        offer_t e;
        check({tag, ".take"}, 32'(o_take), 32'd1);
        n_tests++;
        assert (offer_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s.sb: observed empty offer queue expected a queued offer", tag);
        end
        if (offer_q.size() != 0) begin
            e = offer_q.pop_front();
            check({tag, ".vector"}, o_vector, e.vec);
            check({tag, ".idx"}, 32'(o_idx), 32'(e.idx));
            check({tag, ".tail"}, 32'(o_tail), 32'(e.tail));
        end
    endtask

    task automatic check_clr(input string tag);
        logic [IdxWidth-1:0] e;
        check({tag, ".clr_we"}, 32'(o_clr_we), 32'd1);
        n_tests++;
        assert (clr_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s.clr_sb: observed empty clear queue expected a queued clear", tag);
        end
        if (clr_q.size() != 0) begin
            e = clr_q.pop_front();
            check({tag, ".clr_idx"}, 32'(o_clr_idx), 32'(e));
        end
    endtask

    task automatic check_cur(input string tag, input int idx, input int prio, input int depth);
        check({tag, ".cur_idx"}, 32'(o_cur_idx), 32'(idx));
        check({tag, ".cur_prio"}, 32'(o_cur_prio), 32'(prio));
        check({tag, ".depth"}, 32'(o_depth), 32'(depth));
    endtask

    // Offer idx/prio from the current level, accept it, check the clear pulse.
    task automatic take_and_ack(input string tag, input int idx, input int prio, input int depth);
        drive_arb(1'b1, idx, prio);
        expect_offer(idx, 1'b0);
        tick();
        check_offer(tag);
        i_ack = 1'b1;
        clr_q.push_back(IdxWidth'(idx));
        tick();
        i_ack = 1'b0;
        drive_arb(1'b0, 0, 0);
        check_clr(tag);
        check_cur(tag, idx, prio, depth);
    endtask

    task automatic mret();
        i_mret = 1'b1;
        tick();
        i_mret = 1'b0;
    endtask

    // Stimulus sanity: the core never acks and retires in the same cycle.
    always @(posedge clk) begin
        if (reset === 1'b1) begin
            assert (!(i_mret && i_ack)) else begin
                n_fail++;
                $error("FAIL illegal_stim: observed i_mret=1 i_ack=1 expected not both");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        i_int       = 1'b0;
        i_idx       = '0;
        i_prio      = '0;
        i_global_ie = 1'b1;
        i_ack       = 1'b0;
        i_mret      = 1'b0;
        for (int i = 0; i < NInt; i++) begin
            i_vectors[i*VW +: VW] = vec_of(i);
        end

        // Reset state
        tick();
        tick();
        check("rst.take", 32'(o_take), 32'd0);
        check("rst.clr_we", 32'(o_clr_we), 32'd0);
        check("rst.overflow", 32'(o_overflow), 32'd0);
        check_cur("rst", 0, 0, 0);
        reset = 1'b1;
        tick();

        // Base take, offer held through PEND despite a higher arrival and ie drop
        drive_arb(1'b1, 3, 5);
        expect_offer(3, 1'b0);
        tick();
        check_offer("base");
        drive_arb(1'b1, 7, 9);
        tick();
        check("pend_hold.take", 32'(o_take), 32'd1);
        check("pend_hold.idx", 32'(o_idx), 32'd3);
        check("pend_hold.vector", o_vector, 32'h100);
        i_global_ie = 1'b0;
        tick();
        check("pend_ie_off.take", 32'(o_take), 32'd1);
        i_global_ie = 1'b1;
        drive_arb(1'b1, 3, 5);
        i_ack = 1'b1;
        clr_q.push_back(IdxWidth'(3));
        tick();
        i_ack = 1'b0;
        check_clr("base");
        check_cur("base", 3, 5, 1);
        check("base.take_after_ack", 32'(o_take), 32'd0);
        tick();
        check("stale_pend.take", 32'(o_take), 32'd0);
        check("stale_pend.clr_we", 32'(o_clr_we), 32'd0);
        drive_arb(1'b0, 0, 0);

        // Preempt and return
        take_and_ack("preempt", 7, 9, 2);
        mret();
        check_cur("ret1", 3, 5, 1);
        mret();
        check_cur("ret2", 0, 0, 0);
        check("ret2.take", 32'(o_take), 32'd0);

        // Withdraw a normal offer from IDLE with mret, then re-qualify
        drive_arb(1'b1, 2, 3);
        expect_offer(2, 1'b0);
        tick();
        check_offer("wd");
        i_mret = 1'b1;
        expect_offer(2, 1'b0);
        tick();
        i_mret = 1'b0;
        check("wd.take", 32'(o_take), 32'd0);
        check("wd.depth", 32'(o_depth), 32'd0);
        tick();
        check_offer("wd_req");
        i_ack = 1'b1;
        clr_q.push_back(IdxWidth'(2));
        tick();
        i_ack = 1'b0;
        drive_arb(1'b0, 0, 0);
        check_clr("wd_req");
        check_cur("wd_req", 2, 3, 1);
        mret();
        check_cur("wd_ret", 0, 0, 0);

        // Equal, lower, out-of-range and disabled winners never taken
        take_and_ack("run5", 3, 5, 1);
        drive_arb(1'b1, 5, 5);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("eq_prio.take", 32'(o_take), 32'd0);
        end
        drive_arb(1'b1, 6, 2);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("low_prio.take", 32'(o_take), 32'd0);
        end
        drive_arb(1'b1, 20, 15);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bad_idx.take", 32'(o_take), 32'd0);
        end
        i_global_ie = 1'b0;
        drive_arb(1'b1, 8, 15);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ie_off.take", 32'(o_take), 32'd0);
        end
        drive_arb(1'b0, 0, 0);
        i_global_ie = 1'b1;
        mret();
        check_cur("run5_ret", 0, 0, 0);

        // Tail-chain at mret
        take_and_ack("t_base", 7, 9, 1);
        drive_arb(1'b1, 4, 6);
        tick();
        check("t_low.take", 32'(o_take), 32'd0);
        i_mret = 1'b1;
        expect_offer(4, 1'b1);
        tick();
        i_mret = 1'b0;
        check_offer("tail");
        check_cur("tail_pend", 7, 9, 1);
        i_ack = 1'b1;
        clr_q.push_back(IdxWidth'(4));
        tick();
        i_ack = 1'b0;
        drive_arb(1'b0, 0, 0);
        check_clr("tail");
        check_cur("tail", 4, 6, 1);
        mret();
        check_cur("tail_ret", 0, 0, 0);

        // Overflow with a full stack, sticky through returns
        take_and_ack("ovf1", 1, 3, 1);
        take_and_ack("ovf2", 6, 6, 2);
        check("ovf.pre", 32'(o_overflow), 32'd0);
        drive_arb(1'b1, 9, 9);
        tick();
        tick();
        check("ovf.take", 32'(o_take), 32'd0);
        check("ovf.flag", 32'(o_overflow), 32'd1);
        drive_arb(1'b0, 0, 0);
        mret();
        check_cur("ovf_ret1", 1, 3, 1);
        mret();
        check_cur("ovf_ret2", 0, 0, 0);
        check("ovf.sticky", 32'(o_overflow), 32'd1);

        // Asynchronous reset in the middle of PEND
        drive_arb(1'b1, 3, 5);
        expect_offer(3, 1'b0);
        tick();
        check_offer("rst_pend");
        i_ack = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst.take", 32'(o_take), 32'd0);
        check("async_rst.overflow", 32'(o_overflow), 32'd0);
        check_cur("async_rst", 0, 0, 0);
        i_ack = 1'b0;
        drive_arb(1'b0, 0, 0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst.clr_we", 32'(o_clr_we), 32'd0);
            check("post_rst.take", 32'(o_take), 32'd0);
        end

        check("sb.offers_left", 32'(offer_q.size()), 32'd0);
        check("sb.clears_left", 32'(clr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
